// File: rtl/sim_host_monitor_pkg.sv
// Shared states and default addresses for the simulation host monitor.
package sim_host_monitor_pkg;

  typedef enum logic [1:0] {
    SIM_ST_RUN   = 2'd0,
    SIM_ST_DRAIN = 2'd1,
    SIM_ST_HALT  = 2'd2
  } sim_state_e;

  localparam int unsigned SIM_TOHOST_PASS = 1;

  localparam logic [63:0] SIM_TOHOST_ADDR_DEFAULT  = 64'h0000_F000;
  localparam logic [63:0] SIM_CONSOLE_ADDR_DEFAULT = 64'h0000_F004;

endpackage

// File: rtl/sim_host_monitor_fifo.sv
// Synchronous FIFO with occupancy count; head data is read straight from the storage registers.
module sim_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset too so the head byte reads 0 after reset rather than X.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sim_host_monitor.sv
// Simulation host monitor: snoops tohost/console stores, buffers console bytes, counts, and halts.
module sim_host_monitor
  import sim_host_monitor_pkg::*;
#(
  parameter int               XLEN           = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(SIM_TOHOST_ADDR_DEFAULT),
  parameter logic [XLEN-1:0]  CONSOLE_ADDR   = XLEN'(SIM_CONSOLE_ADDR_DEFAULT),
  parameter int               CON_DEPTH      = 16,
  parameter logic [63:0]      TIMEOUT_CYCLES = 64'd1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [XLEN-1:0]   st_addr,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN/8-1:0] st_be,
  input  logic              retire,
  output logic              con_valid,
  output logic [7:0]        con_data,
  input  logic              con_ready,
  output logic              con_overflow,
  output logic              halted,
  output logic              pass,
  output logic              timed_out,
  output logic [XLEN-1:0]   exit_code,
  output logic [63:0]       cycle_count,
  output logic [63:0]       instret_count
);

  localparam int CW = $clog2(CON_DEPTH) + 1;

  sim_state_e state;
  sim_state_e next_state;

  logic          in_run;
  logic          tohost_hit;
  logic          console_hit;
  logic          wd_fire;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign in_run      = (state == SIM_ST_RUN);
  assign tohost_hit  = in_run && st_valid && (st_addr == TOHOST_ADDR) && (&st_be) && st_data[0];
  assign console_hit = in_run && st_valid && (st_addr == CONSOLE_ADDR) && st_be[0];
  // A tohost hit in the watchdog cycle takes priority, so the timeout is masked.
  assign wd_fire     = in_run && (TIMEOUT_CYCLES != 64'd0) && !tohost_hit &&
                       (cycle_count == TIMEOUT_CYCLES - 64'd1);

  assign con_valid = !fifo_empty;
  assign fifo_pop  = con_valid && con_ready;
  assign fifo_push = console_hit;
  assign halted    = (state == SIM_ST_HALT);

  sim_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (st_data[7:0]),
    .rdata (con_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SIM_ST_RUN;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      SIM_ST_RUN:   if (tohost_hit || wd_fire) next_state = SIM_ST_DRAIN;
      SIM_ST_DRAIN: if (fifo_count == '0)      next_state = SIM_ST_HALT;
      SIM_ST_HALT:  next_state = SIM_ST_HALT;
      default:      next_state = SIM_ST_RUN;
    endcase
  end

  // NOTE: all clocked state below uses non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
      pass          <= 1'b0;
      timed_out     <= 1'b0;
      exit_code     <= '0;
      con_overflow  <= 1'b0;
    end else begin
      if (in_run && !tohost_hit) begin
        cycle_count <= cycle_count + 64'd1;
        if (retire) instret_count <= instret_count + 64'd1;
      end
      if (tohost_hit) begin
        exit_code <= st_data >> 1;
        pass      <= (st_data == XLEN'(SIM_TOHOST_PASS));
      end else if (wd_fire) begin
        timed_out <= 1'b1;
        pass      <= 1'b0;
        exit_code <= '1;
      end
      if (console_hit && fifo_full && !fifo_pop) con_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_host_monitor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_sim_host_monitor;

  localparam int          DEPTH   = 16;
  localparam int          TIMEOUT = 50;
  localparam logic [31:0] TOHOST  = 32'h0000_F000;
  localparam logic [31:0] CONSOLE = 32'h0000_F004;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        retire;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        con_overflow;
  logic        halted;
  logic        pass;
  logic        timed_out;
  logic [31:0] exit_code;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sim_host_monitor #(
    .XLEN           (32),
    .TOHOST_ADDR    (TOHOST),
    .CONSOLE_ADDR   (CONSOLE),
    .CON_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (64'd50)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_be         (st_be),
    .retire        (retire),
    .con_valid     (con_valid),
    .con_data      (con_data),
    .con_ready     (con_ready),
    .con_overflow  (con_overflow),
    .halted        (halted),
    .pass          (pass),
    .timed_out     (timed_out),
    .exit_code     (exit_code),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );

  // Reference model: phase 0 = running, 1 = draining, 2 = halted.
  logic [7:0]      mq[$];
  longint unsigned m_cycles;
  longint unsigned m_instret;
  int              m_phase;
  bit              m_pass;
  bit              m_timed;
  bit              m_ovf;
  logic [31:0]     m_exit;

  task automatic model_reset();
    mq.delete();
    m_cycles  = 0;
    m_instret = 0;
    m_phase   = 0;
    m_pass    = 0;
    m_timed   = 0;
    m_ovf     = 0;
    m_exit    = '0;
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic step();
    bit pop  = (mq.size() != 0) && con_ready;
    bit full = (mq.size() == DEPTH);
    bit th   = st_valid && (st_addr == TOHOST) && (st_be == 4'hF) && st_data[0];
    bit cn   = st_valid && (st_addr == CONSOLE) && st_be[0];
    if (m_phase == 0) begin
      if (pop) void'(mq.pop_front());
      if (cn) begin
        if (full && !pop) m_ovf = 1;
        else mq.push_back(st_data[7:0]);
      end
      if (th) begin
        m_exit  = st_data >> 1;
        m_pass  = (st_data == 32'd1);
        m_phase = 1;
      end else begin
        if (m_cycles == longint'(TIMEOUT - 1)) begin
          m_timed = 1;
          m_pass  = 0;
          m_exit  = 32'hFFFF_FFFF;
          m_phase = 1;
        end
        m_cycles++;
        if (retire) m_instret++;
      end
    end else if (m_phase == 1) begin
      if (mq.size() == 0) m_phase = 2;
      else if (pop) void'(mq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    st_valid  = 0;
    st_addr   = '0;
    st_data   = '0;
    st_be     = '0;
    retire    = 0;
    con_ready = 0;
    reset     = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    st_valid = 1;
    st_addr  = addr;
    st_data  = data;
    st_be    = be;
    step();
    st_valid = 0;
    st_be    = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 9;
    if (con_valid !== 1'b0)       begin n_errors++; $display("FAIL rst_con_valid got=%b exp=0", con_valid); end
    if (con_data !== 8'h00)       begin n_errors++; $display("FAIL rst_con_data got=%h exp=00", con_data); end
    if (con_overflow !== 1'b0)    begin n_errors++; $display("FAIL rst_overflow got=%b exp=0", con_overflow); end
    if (halted !== 1'b0)          begin n_errors++; $display("FAIL rst_halted got=%b exp=0", halted); end
    if (pass !== 1'b0)            begin n_errors++; $display("FAIL rst_pass got=%b exp=0", pass); end
    if (timed_out !== 1'b0)       begin n_errors++; $display("FAIL rst_timed_out got=%b exp=0", timed_out); end
    if (exit_code !== 32'h0)      begin n_errors++; $display("FAIL rst_exit_code got=%h exp=0", exit_code); end
    if (cycle_count !== 64'd0)    begin n_errors++; $display("FAIL rst_cycle got=%0d exp=0", cycle_count); end
    if (instret_count !== 64'd0)  begin n_errors++; $display("FAIL rst_instret got=%0d exp=0", instret_count); end
  endtask

  task automatic test_tohost_pass();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      retire = (i % 3 == 0);
      step();
    end
    retire = 0;
    drive_store(TOHOST, 32'h1, 4'hF);
    n_checks++;
    if (halted !== 1'b0) begin n_errors++; $display("FAIL pass_drain_halted got=%b exp=0", halted); end
    step();
    n_checks += 6;
    if (halted !== 1'b1)          begin n_errors++; $display("FAIL pass_halted got=%b exp=1", halted); end
    if (pass !== 1'b1)            begin n_errors++; $display("FAIL pass_pass got=%b exp=1", pass); end
    if (timed_out !== 1'b0)       begin n_errors++; $display("FAIL pass_timed_out got=%b exp=0", timed_out); end
    if (exit_code !== 32'h0)      begin n_errors++; $display("FAIL pass_exit got=%h exp=0", exit_code); end
    if (cycle_count !== 64'd10)   begin n_errors++; $display("FAIL pass_cycle got=%0d exp=10", cycle_count); end
    if (instret_count !== 64'd4)  begin n_errors++; $display("FAIL pass_instret got=%0d exp=4", instret_count); end
  endtask

  task automatic test_tohost_fail();
    do_reset();
    drive_store(TOHOST, 32'h6, 4'hF);
    step();
    step();
    n_checks += 2;
    if (halted !== 1'b0)     begin n_errors++; $display("FAIL fail_even_halted got=%b exp=0", halted); end
    if (exit_code !== 32'h0) begin n_errors++; $display("FAIL fail_even_exit got=%h exp=0", exit_code); end
    drive_store(TOHOST, 32'h7, 4'h7);
    step();
    n_checks++;
    if (halted !== 1'b0)     begin n_errors++; $display("FAIL fail_partial_halted got=%b exp=0", halted); end
    drive_store(TOHOST, 32'h7, 4'hF);
    step();
    n_checks += 3;
    if (halted !== 1'b1)     begin n_errors++; $display("FAIL fail_halted got=%b exp=1", halted); end
    if (pass !== 1'b0)       begin n_errors++; $display("FAIL fail_pass got=%b exp=0", pass); end
    if (exit_code !== 32'h3) begin n_errors++; $display("FAIL fail_exit got=%h exp=3", exit_code); end
  endtask

  task automatic test_console_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) drive_store(CONSOLE, 32'h41 + i, 4'h1);
    n_checks += 3;
    if (con_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got=%b exp=1", con_overflow); end
    if (con_valid !== 1'b1)    begin n_errors++; $display("FAIL ovf_valid got=%b exp=1", con_valid); end
    if (con_data !== 8'h41)    begin n_errors++; $display("FAIL ovf_head got=%h exp=41", con_data); end
    con_ready = 1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_b = 8'(8'h41 + i);
      n_checks++;
      if (con_valid !== 1'b1 || con_data !== exp_b) begin
        n_errors++;
        $display("FAIL ovf_drain_%0d got=%b/%h exp=1/%h", i, con_valid, con_data, exp_b);
      end
      step();
    end
    con_ready = 0;
    n_checks += 2;
    if (con_valid !== 1'b0)    begin n_errors++; $display("FAIL ovf_empty got=%b exp=0", con_valid); end
    if (con_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got=%b exp=1", con_overflow); end
  endtask

  task automatic test_drain();
    do_reset();
    drive_store(CONSOLE, 32'h68, 4'h1);
    drive_store(CONSOLE, 32'h69, 4'h1);
    drive_store(TOHOST, 32'h1, 4'hF);
    drive_store(CONSOLE, 32'h78, 4'h1);
    step();
    n_checks += 3;
    if (halted !== 1'b0)    begin n_errors++; $display("FAIL drain_wait_halted got=%b exp=0", halted); end
    if (con_valid !== 1'b1) begin n_errors++; $display("FAIL drain_wait_valid got=%b exp=1", con_valid); end
    if (pass !== 1'b1)      begin n_errors++; $display("FAIL drain_wait_pass got=%b exp=1", pass); end
    con_ready = 1;
    n_checks++;
    if (con_data !== 8'h68) begin n_errors++; $display("FAIL drain_byte_h got=%h exp=68", con_data); end
    step();
    n_checks++;
    if (con_data !== 8'h69) begin n_errors++; $display("FAIL drain_byte_i got=%h exp=69", con_data); end
    step();
    n_checks += 2;
    if (con_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty got=%b exp=0", con_valid); end
    if (halted !== 1'b0)    begin n_errors++; $display("FAIL drain_early_halt got=%b exp=0", halted); end
    step();
    n_checks++;
    if (halted !== 1'b1)    begin n_errors++; $display("FAIL drain_halted got=%b exp=1", halted); end
    con_ready = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 200 && halted !== 1'b1; i++) step();
    n_checks += 6;
    if (halted !== 1'b1)             begin n_errors++; $display("FAIL wd_halted got=%b exp=1 (bound expired)", halted); end
    if (timed_out !== 1'b1)          begin n_errors++; $display("FAIL wd_timed_out got=%b exp=1", timed_out); end
    if (exit_code !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wd_exit got=%h exp=ffffffff", exit_code); end
    if (cycle_count !== 64'd50)      begin n_errors++; $display("FAIL wd_cycle got=%0d exp=50", cycle_count); end
    if (pass !== 1'b0)               begin n_errors++; $display("FAIL wd_pass got=%b exp=0", pass); end
    if (instret_count !== 64'd0)     begin n_errors++; $display("FAIL wd_instret got=%0d exp=0", instret_count); end
  endtask

  task automatic test_timeout_tohost();
    do_reset();
    repeat (49) step();
    n_checks++;
    if (cycle_count !== 64'd49) begin n_errors++; $display("FAIL wdth_pre_cycle got=%0d exp=49", cycle_count); end
    drive_store(TOHOST, 32'h1, 4'hF);
    step();
    n_checks += 5;
    if (halted !== 1'b1)        begin n_errors++; $display("FAIL wdth_halted got=%b exp=1", halted); end
    if (pass !== 1'b1)          begin n_errors++; $display("FAIL wdth_pass got=%b exp=1", pass); end
    if (timed_out !== 1'b0)     begin n_errors++; $display("FAIL wdth_timed_out got=%b exp=0", timed_out); end
    if (exit_code !== 32'h0)    begin n_errors++; $display("FAIL wdth_exit got=%h exp=0", exit_code); end
    if (cycle_count !== 64'd49) begin n_errors++; $display("FAIL wdth_cycle got=%0d exp=49", cycle_count); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    drive_store(CONSOLE, 32'h31, 4'h1);
    drive_store(CONSOLE, 32'h32, 4'h1);
    drive_store(CONSOLE, 32'h33, 4'h1);
    drive_store(TOHOST, 32'h5, 4'hF);
    n_checks += 2;
    if (exit_code !== 32'h2) begin n_errors++; $display("FAIL rdr_pre_exit got=%h exp=2", exit_code); end
    if (con_valid !== 1'b1)  begin n_errors++; $display("FAIL rdr_pre_valid got=%b exp=1", con_valid); end
    #2 reset = 1;
    #1;
    n_checks += 6;
    if (con_valid !== 1'b0)       begin n_errors++; $display("FAIL rdr_valid got=%b exp=0", con_valid); end
    if (con_data !== 8'h00)       begin n_errors++; $display("FAIL rdr_data got=%h exp=00", con_data); end
    if (halted !== 1'b0)          begin n_errors++; $display("FAIL rdr_halted got=%b exp=0", halted); end
    if (exit_code !== 32'h0)      begin n_errors++; $display("FAIL rdr_exit got=%h exp=0", exit_code); end
    if (cycle_count !== 64'd0)    begin n_errors++; $display("FAIL rdr_cycle got=%0d exp=0", cycle_count); end
    if (pass !== 1'b0)            begin n_errors++; $display("FAIL rdr_pass got=%b exp=0", pass); end
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    repeat (5) step();
    n_checks += 3;
    if (cycle_count !== 64'd5) begin n_errors++; $display("FAIL rdr_resume_cycle got=%0d exp=5", cycle_count); end
    if (con_valid !== 1'b0)    begin n_errors++; $display("FAIL rdr_resume_valid got=%b exp=0", con_valid); end
    if (halted !== 1'b0)       begin n_errors++; $display("FAIL rdr_resume_halted got=%b exp=0", halted); end
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 6; iter++) begin
      do_reset();
      for (int cyc = 0; cyc < 90; cyc++) begin
        int r = $urandom_range(0, 99);
        st_valid = (r < 60);
        st_be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        st_data  = $urandom;
        if (r < 4) begin
          st_addr = TOHOST;
          if ($urandom_range(0, 1) == 0) st_data = 32'h1;
        end else if (r < 50) begin
          st_addr = CONSOLE;
        end else begin
          st_addr = $urandom;
        end
        retire    = $urandom_range(0, 1);
        con_ready = ($urandom_range(0, 2) < iter % 3);
        step();
        n_checks += 8;
        if (con_valid !== (mq.size() != 0))
          begin n_errors++; $display("FAIL rnd_valid it=%0d c=%0d got=%b exp=%b", iter, cyc, con_valid, mq.size() != 0); end
        if (mq.size() != 0 && con_data !== mq[0])
          begin n_errors++; $display("FAIL rnd_data it=%0d c=%0d got=%h exp=%h", iter, cyc, con_data, mq[0]); end
        if (con_overflow !== m_ovf)
          begin n_errors++; $display("FAIL rnd_ovf it=%0d c=%0d got=%b exp=%b", iter, cyc, con_overflow, m_ovf); end
        if (halted !== (m_phase == 2))
          begin n_errors++; $display("FAIL rnd_halted it=%0d c=%0d got=%b exp=%b", iter, cyc, halted, m_phase == 2); end
        if (pass !== m_pass || timed_out !== m_timed)
          begin n_errors++; $display("FAIL rnd_pass_to it=%0d c=%0d got=%b%b exp=%b%b", iter, cyc, pass, timed_out, m_pass, m_timed); end
        if (exit_code !== m_exit)
          begin n_errors++; $display("FAIL rnd_exit it=%0d c=%0d got=%h exp=%h", iter, cyc, exit_code, m_exit); end
        if (cycle_count !== m_cycles)
          begin n_errors++; $display("FAIL rnd_cycle it=%0d c=%0d got=%0d exp=%0d", iter, cyc, cycle_count, m_cycles); end
        if (instret_count !== m_instret)
          begin n_errors++; $display("FAIL rnd_instret it=%0d c=%0d got=%0d exp=%0d", iter, cyc, instret_count, m_instret); end
      end
    end
    st_valid  = 0;
    con_ready = 0;
  endtask

  initial begin
    test_reset();
    test_tohost_pass();
    test_tohost_fail();
    test_console_overflow();
    test_drain();
    test_timeout();
    test_timeout_tohost();
    test_reset_in_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit reached");
  end

endmodule
